sseg_display_arbiter: RTL

Time-shares the four-digit seven-segment display between three activity sources: floppy, harddisk and control-block message. It falls back to a default value when none is active. It sits between the I/O status sources and the board display pins, in the indicators area. Each grant is held for a minimum time and lingers before the display returns to idle. Priority is evaluated only at decision points, so no source can flicker the display or starve it.

---
 rtl/io_pkg.sv | 26 ++
 rtl/sseg_decode.sv | 53 +++++
 rtl/sseg_display_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the I/O status indicators: source indices, arbiter states, display constants.
package io_pkg;

  localparam int SRC_FLOPPY = 0;
  localparam int SRC_HDD    = 1;
  localparam int SRC_MSG    = 2;

  localparam logic [6:0] SSEG_OFF = 7'h7f;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_LINGER = 2'd2
  } arb_state_t;

  // Fixed priority: message > harddisk > floppy; returns one-hot or zero.
  function automatic logic [2:0] pick_winner(input logic [2:0] c);
    logic [2:0] w;
    w = '0;
    if (c[SRC_MSG])         w[SRC_MSG]    = 1'b1;
    else if (c[SRC_HDD])    w[SRC_HDD]    = 1'b1;
    else if (c[SRC_FLOPPY]) w[SRC_FLOPPY] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Hex nibble to seven-segment decoder (bit0 = segment a), optional output
// inversion for active-low pins and optional output register.
module sseg_decode #(
  parameter bit REG = 1'b1,
  parameter bit INV = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  logic [6:0] raw;
  logic [6:0] pol;

  always_comb begin
    raw = 7'h00;
    case (nib)
      4'h0: raw = 7'h3f;
      4'h1: raw = 7'h06;
      4'h2: raw = 7'h5b;
      4'h3: raw = 7'h4f;
      4'h4: raw = 7'h66;
      4'h5: raw = 7'h6d;
      4'h6: raw = 7'h7d;
      4'h7: raw = 7'h07;
      4'h8: raw = 7'h7f;
      4'h9: raw = 7'h6f;
      4'ha: raw = 7'h77;
      4'hb: raw = 7'h7c;
      4'hc: raw = 7'h39;
      4'hd: raw = 7'h5e;
      4'he: raw = 7'h79;
      4'hf: raw = 7'h71;
      default: raw = 7'h00;
    endcase
  end

  assign pol = INV ? ~raw : raw;

  generate
    if (REG) begin : g_reg
      // Reset to all segments dark in either polarity.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) seg <= {7{INV}};
        else     seg <= pol;
      end
    end else begin : g_comb
      assign seg = pol;
    end
  endgenerate

endmodule

// File: rtl/sseg_display_arbiter.sv
// Time-shares the 4-digit display among floppy/harddisk/message with minimum hold
// and linger times; priority is only evaluated at decision points.
module sseg_display_arbiter
  import io_pkg::*;
#(
  parameter int HOLD_CYC   = 2_500_000,
  parameter int LINGER_CYC = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [3:0]  blk0,
  input  logic [3:0]  blk1,
  input  logic [3:0]  blk2,
  input  logic [15:0] dflt_val,
  input  logic [3:0]  dflt_blk,
  output logic [6:0]  hex_0,
  output logic [6:0]  hex_1,
  output logic [6:0]  hex_2,
  output logic [6:0]  hex_3,
  output logic [2:0]  owner,
  output logic        busy
);

  localparam int CNT_MAX = (HOLD_CYC > LINGER_CYC) ? HOLD_CYC : LINGER_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LINGER_LD = CW'(LINGER_CYC - 1);

  arb_state_t    state, state_n;
  logic [2:0]    owner_n;
  logic [2:0]    pend, pend_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    cand;
  logic [2:0]    others;
  logic [2:0]    grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  end

  assign cand   = pend | req;
  assign others = cand & ~owner;

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    grant   = '0;
    case (state)
      ST_IDLE: begin
        if (|cand) begin
          grant   = pick_winner(cand);
          owner_n = grant;
          cnt_n   = HOLD_LD;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The owner's own requests are not considered here, so it cannot extend itself.
        if (cnt == '0) begin
          if (|others) begin
            grant   = pick_winner(others);
            owner_n = grant;
            cnt_n   = HOLD_LD;
          end else begin
            cnt_n   = LINGER_LD;
            state_n = ST_LINGER;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_LINGER: begin
        if (|cand) begin
          grant   = pick_winner(cand);
          owner_n = grant;
          cnt_n   = HOLD_LD;
          state_n = ST_HOLD;
        end else if (cnt == '0) begin
          owner_n = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        owner_n = '0;
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
    // Only the granted source is cleared; a new req elsewhere always sticks.
    pend_n = cand & ~grant;
  end

  assign busy = (state != ST_IDLE);

  logic [15:0] sel_val;
  logic [3:0]  sel_blk;
  logic [3:0]  blk_q;
  logic [6:0]  dec [4];

  always_comb begin
    sel_val = dflt_val;
    sel_blk = dflt_blk;
    if (owner[SRC_MSG]) begin
      sel_val = val2;
      sel_blk = blk2;
    end else if (owner[SRC_HDD]) begin
      sel_val = val1;
      sel_blk = blk1;
    end else if (owner[SRC_FLOPPY]) begin
      sel_val = val0;
      sel_blk = blk0;
    end
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_dig
      sseg_decode #(.REG(1'b1), .INV(1'b1)) u_dec (
        .clk (clk),
        .rst (rst),
        .nib (sel_val[4*k +: 4]),
        .seg (dec[k])
      );
    end
  endgenerate

  // Blank mask registered alongside the decoders so both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_q <= 4'hf;
    else     blk_q <= sel_blk;
  end

  assign hex_0 = blk_q[0] ? SSEG_OFF : dec[0];
  assign hex_1 = blk_q[1] ? SSEG_OFF : dec[1];
  assign hex_2 = blk_q[2] ? SSEG_OFF : dec[2];
  assign hex_3 = blk_q[3] ? SSEG_OFF : dec[3];

endmodule
